// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the framebuffer port arbiter.
// Build option FB_ARB_STALL_CNT_EN is consumed by fb_port_arbiter.
package fb_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 15;
    localparam int unsigned DATA_W_DEF   = 24;
    localparam int unsigned DEPTH_DEF    = 19200;
    localparam int unsigned DISP_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CLR,
        GNT_WR
    } gnt_e;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address counter and fill colour for the full-screen clear; the counter
// stops at DEPTH-1 instead of wrapping.
module fb_clear_sweeper
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [DATA_W-1:0] color_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] color,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_color;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_color <= '0;
        end else if (start) begin
            r_cnt   <= '0;
            r_color <= color_in;
        end else if (advance && (r_cnt != LAST_ADDR)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign addr  = r_cnt;
    assign color = r_color;
    assign last  = (r_cnt == LAST_ADDR);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear sweep > draw writes.
// Define FB_ARB_STALL_CNT_EN to add the stall_cnt draw-stall counter output.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_e r_state;
    gnt_e       w_gnt;

    logic              w_clr_start;
    logic              w_clr_adv;
    logic              w_clr_last;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_color;

    // bit 0 drives mem_re; the top bit marks the cycle mem_rdata is valid
    logic [DISP_LATENCY-2:0] r_rd_pipe;

    always_comb begin
        w_gnt = GNT_NONE;
        if (disp_req)
            w_gnt = GNT_DISP;
        else if (r_state == CLEAR)
            w_gnt = GNT_CLR;
        else if (wr_req && (r_state == IDLE))
            w_gnt = GNT_WR;
    end

    assign w_clr_start = (r_state == IDLE) && clr_req;
    assign w_clr_adv   = (w_gnt == GNT_CLR);
    assign wr_ack      = (w_gnt == GNT_WR);
    assign clr_busy    = (r_state == CLEAR);
    assign clr_done    = (r_state == DONE);
    assign mem_re      = r_rd_pipe[0];

    fb_clear_sweeper #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sweeper (
        .clk      (clk),
        .rst      (rst),
        .start    (w_clr_start),
        .advance  (w_clr_adv),
        .color_in (clr_color),
        .addr     (w_clr_addr),
        .color    (w_clr_color),
        .last     (w_clr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (clr_req) r_state <= CLEAR;
                CLEAR:   if (w_clr_adv && w_clr_last) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pipe  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[DISP_LATENCY-3:0], (w_gnt == GNT_DISP)};
            mem_we    <= (w_gnt == GNT_CLR) || (w_gnt == GNT_WR);
            case (w_gnt)
                GNT_DISP: mem_addr <= disp_addr;
                GNT_CLR: begin
                    mem_addr  <= w_clr_addr;
                    mem_wdata <= w_clr_color;
                end
                GNT_WR: begin
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
                default: ;
            endcase
            disp_valid <= r_rd_pipe[DISP_LATENCY-2];
            if (r_rd_pipe[DISP_LATENCY-2])
                disp_data <= mem_rdata;
        end
    end

`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_clr_start)
            r_stall_cnt <= '0;
        else if (wr_req && !wr_ack && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a one-cycle-latency RAM model.
// Also exercises stall_cnt when built with FB_ARB_STALL_CNT_EN.
module tb_fb_port_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic              clr_req = 1'b0;
    logic [DATA_W-1:0] clr_color = '0;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clr_req    (clr_req),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
`ifdef FB_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // RAM model: unwritten locations return a fixed address-derived pattern
    logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
    bit                ram_wv [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] pat(input int a);
        case (a)
            5:       return 24'hABCDEF;
            7:       return 24'h070707;
            8:       return 24'h080808;
            9:       return 24'h090909;
            default: return 24'(a) ^ 24'h5A5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= ram_wv[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wv[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              d_req;
        logic [ADDR_W-1:0] d_addr;
        logic              w_req;
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              e_ack;
        logic              e_re;
        logic              e_we;
        logic              ck_a;
        logic              ck_d;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic              e_dv;
        logic [DATA_W-1:0] e_dd;
    } vec_t;

    vec_t vt [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // display read, draw write, display/draw collision; one row per cycle
        vt[0]  = '{1, 5,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      0, 24'h0};
        vt[1]  = '{0, 0,   0, 0,   24'h0,      0, 1, 0, 1, 0, 5,   24'h0,      0, 24'h0};
        vt[2]  = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      0, 24'h0};
        vt[3]  = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      1, 24'hABCDEF};
        vt[4]  = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      0, 24'hABCDEF};
        vt[5]  = '{0, 0,   1, 100, 24'h00FF00, 1, 0, 0, 0, 0, 0,   24'h0,      0, 24'hABCDEF};
        vt[6]  = '{0, 0,   0, 0,   24'h0,      0, 0, 1, 1, 1, 100, 24'h00FF00, 0, 24'hABCDEF};
        vt[7]  = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      0, 24'hABCDEF};
        vt[8]  = '{1, 7,   1, 200, 24'h123456, 0, 0, 0, 0, 0, 0,   24'h0,      0, 24'hABCDEF};
        vt[9]  = '{1, 8,   1, 200, 24'h123456, 0, 1, 0, 1, 0, 7,   24'h0,      0, 24'hABCDEF};
        vt[10] = '{1, 9,   1, 200, 24'h123456, 0, 1, 0, 1, 0, 8,   24'h0,      0, 24'hABCDEF};
        vt[11] = '{0, 0,   1, 200, 24'h123456, 1, 1, 0, 1, 0, 9,   24'h0,      1, 24'h070707};
        vt[12] = '{0, 0,   0, 0,   24'h0,      0, 0, 1, 1, 1, 200, 24'h123456, 1, 24'h080808};
        vt[13] = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      1, 24'h090909};
        vt[14] = '{0, 0,   0, 0,   24'h0,      0, 0, 0, 0, 0, 0,   24'h0,      0, 24'h090909};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_disp_data", 32'(disp_data), 32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            disp_req  = vt[i].d_req;
            disp_addr = vt[i].d_addr;
            wr_req    = vt[i].w_req;
            wr_addr   = vt[i].w_addr;
            wr_data   = vt[i].w_data;
            @(negedge clk);
            chk($sformatf("v%0d_wr_ack", i), 32'(wr_ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_mem_re", i), 32'(mem_re), 32'(vt[i].e_re));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
            if (vt[i].ck_a)
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
            if (vt[i].ck_d)
                chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].e_wdata));
            chk($sformatf("v%0d_disp_valid", i), 32'(disp_valid), 32'(vt[i].e_dv));
            chk($sformatf("v%0d_disp_data", i), 32'(disp_data), 32'(vt[i].e_dd));
            @(posedge clk); #1;
        end

        // full clear with a draw request held across it
        begin
            int nw = 0, ndone = 0, done_cyc = -1, ack_cyc = -1, bsy_bad = 0, both = 0;
            bit acked = 0;
            disp_req = 1'b0;
            for (int c = 0; c < 30; c++) begin
                clr_req   = (c == 0);
                clr_color = 24'hFFFFFF;
                wr_req    = (c >= 1) && !acked;
                wr_addr   = 15'd300;
                wr_data   = 24'h0000AA;
                @(negedge clk);
                if (c == 0) chk("clr_busy_before", 32'(clr_busy), 32'h0);
                if (mem_we && mem_re) both++;
                if (c >= 1 && c <= 16 && !clr_busy) bsy_bad++;
                if (mem_we && mem_wdata == 24'hFFFFFF) begin
                    chk("clr_addr", 32'(mem_addr), 32'(nw));
                    chk("clr_slot", 32'(c), 32'(nw + 2));
                    nw++;
                end
                if (clr_done) begin ndone++; done_cyc = c; end
                if (wr_ack) begin ack_cyc = c; acked = 1; end
                @(posedge clk); #1;
            end
            chk("clr_nwrites", 32'(nw), 32'(DEPTH));
            chk("clr_ndone", 32'(ndone), 32'd1);
            chk("clr_done_cyc", 32'(done_cyc), 32'd17);
            chk("clr_wr_ack_cyc", 32'(ack_cyc), 32'd18);
            chk("clr_busy_gaps", 32'(bsy_bad), 32'd0);
            chk("clr_busy_after", 32'(clr_busy), 32'h0);
            chk("clr_we_re_both", 32'(both), 32'd0);
        end

        // clear interleaved with display reads, then reset mid-sweep
        begin
            int both = 0, late_done = 0, late_busy = 0, late_we = 0;
            wr_req    = 1'b0;
            clr_color = 24'h00FFFF;
            for (int c = 0; c < 16; c++) begin
                clr_req   = (c == 0);
                disp_req  = (c % 2 == 1);
                disp_addr = 15'(1000 + c);
                @(negedge clk);
                if (mem_we && mem_re) both++;
                if (c >= 2 && c % 2 == 0) begin
                    chk("ilv_mem_re", 32'(mem_re), 32'h1);
                    chk("ilv_rd_addr", 32'(mem_addr), 32'(1000 + c - 1));
                end
                if (c >= 3 && c % 2 == 1) begin
                    chk("ilv_mem_we", 32'(mem_we), 32'h1);
                    chk("ilv_wr_addr", 32'(mem_addr), 32'((c - 3) / 2));
                    chk("ilv_wr_data", 32'(mem_wdata), 32'h00FFFF);
                end
                if (c >= 4 && c % 2 == 0) begin
                    chk("ilv_disp_valid", 32'(disp_valid), 32'h1);
                    chk("ilv_disp_data", 32'(disp_data), 32'(pat(1000 + c - 3)));
                end
                @(posedge clk); #1;
            end
            chk("ilv_we_re_both", 32'(both), 32'd0);
            rst      = 1'b1;
            disp_req = 1'b0;
            clr_req  = 1'b0;
            @(negedge clk);
            chk("abort_clr_busy", 32'(clr_busy), 32'h0);
            chk("abort_clr_done", 32'(clr_done), 32'h0);
            chk("abort_mem_re", 32'(mem_re), 32'h0);
            chk("abort_mem_we", 32'(mem_we), 32'h0);
            chk("abort_mem_addr", 32'(mem_addr), 32'h0);
            chk("abort_mem_wdata", 32'(mem_wdata), 32'h0);
            chk("abort_disp_valid", 32'(disp_valid), 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (clr_done) late_done++;
                if (clr_busy) late_busy++;
                if (mem_we) late_we++;
                @(posedge clk); #1;
            end
            chk("abort_no_done", 32'(late_done), 32'd0);
            chk("abort_no_busy", 32'(late_busy), 32'd0);
            chk("abort_no_we", 32'(late_we), 32'd0);
        end

`ifdef FB_ARB_STALL_CNT_EN
        for (int k = 0; k < 7; k++) begin
            disp_req  = (k < 4);
            disp_addr = 15'(2000 + k);
            wr_req    = (k <= 4);
            wr_addr   = 15'd400;
            wr_data   = 24'h000001;
            clr_req   = (k == 5);
            clr_color = 24'h111111;
            @(negedge clk);
            if (k < 4) begin
                chk("stall_cnt_blocked", 32'(stall_cnt), 32'(k));
                chk("stall_wr_ack", 32'(wr_ack), 32'h0);
            end else if (k == 4) begin
                chk("stall_ack", 32'(wr_ack), 32'h1);
                chk("stall_cnt_4", 32'(stall_cnt), 32'd4);
            end else if (k == 5) begin
                chk("stall_cnt_hold", 32'(stall_cnt), 32'd4);
            end else begin
                chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
            end
            @(posedge clk); #1;
        end
        clr_req = 1'b0;
        repeat (25) @(posedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Arbitrates the single-port synchronous framebuffer RAM between three requesters: VGA display scan-out reads, drawing-cursor pixel writes, and a full-screen clear engine.
- Sits between the 800x525 scan counters/colour lookup feeding the VGA output stage and the framebuffer RAM.
- Display reads have absolute priority so scan-out never starves.

Parameters:
ADDR_W, 15, framebuffer address width
DATA_W, 24, pixel width ({b,g,r} 8 bits each)
DEPTH, 19200, number of pixels swept by clear (160x120); must be <= 2**ADDR_W

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
disp_req  in  1  display read request; always accepted
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  read pixel
disp_valid  out  1  disp_data valid pulse
wr_req  in  1  draw write request; held with addr/data until wr_ack
wr_addr  in  ADDR_W  draw write address
wr_data  in  DATA_W  draw write pixel
wr_ack  out  1  one-cycle pulse: write issued to RAM
clr_req  in  1  start clear (level or pulse; sampled only when idle)
clr_color  in  DATA_W  fill colour, captured when clr_req is accepted
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse after the last clear write
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_we  out  1  RAM write enable (registered)
mem_re  out  1  RAM read enable (registered)
mem_rdata  in  DATA_W  RAM read data, one cycle after mem_re

Behaviour:
- Reset: all outputs 0, FSM in IDLE, clear counter 0. Reset mid-clear aborts the sweep; no clr_done is produced.
- Per-cycle grant priority: display > clear > draw. Exactly one grant per cycle, or none.
- Display path:
  - disp_req at cycle N drives mem_re=1, mem_addr=disp_addr at N+1.
  - mem_rdata is registered into disp_data, with disp_valid=1, at N+3.
  - Fixed latency of 3, fully pipelined, one read per cycle sustained.
  - disp_data holds its last value when disp_valid=0.
- Draw path:
  - Granted when wr_req=1, no disp_req, and FSM is IDLE.
  - wr_ack pulses at cycle N, the grant cycle; mem_we=1 with addr/data at N+1.
  - While clr_busy=1, wr_req is stalled (no wr_ack) until the clear completes.
  - The writer must deassert or change wr_req only after wr_ack.
- FSM:
  - IDLE -> CLEAR on clr_req=1: capture clr_color and reset the counter to 0. clr_busy=1 from the next cycle.
  - CLEAR: each cycle with no disp_req, issue a write of the captured colour at the counter address, then increment the counter.
  - CLEAR -> DONE after the write at DEPTH-1 is issued.
  - DONE (one cycle): clr_done=1, clr_busy=0, then -> IDLE.
  - clr_req during CLEAR or DONE is ignored.
- Counter and width rules:
  - Counter is ADDR_W bits and never exceeds DEPTH-1; it does not wrap to reuse addresses.
  - Addresses >= DEPTH on disp_addr/wr_addr are passed through unchecked.
- Simultaneous events:
  - disp_req with wr_req: read wins; retry the write next cycle.
  - disp_req every cycle: clear and draw stall indefinitely (legal; the display issues at most every 2nd cycle in the system).
  - wr_req and clr_req in IDLE in the same cycle: the write is granted this cycle, and the FSM enters CLEAR on the same edge.
- mem_we and mem_re are never both 1.

Optional Feature:
- Macro: FB_ARB_STALL_CNT_EN.
- When defined: adds output stall_cnt [15:0].
  - Increments each cycle wr_req=1 and wr_ack=0; saturates at 16'hFFFF.
  - Clears on rst or on an accepted clr_req.
- When undefined: no port, no logic; all other behaviour is identical.

Decomposition:
- Package fb_arb_pkg holds:
  - FSM state enum (IDLE, CLEAR, DONE)
  - grant code enum (GNT_NONE, GNT_DISP, GNT_CLR, GNT_WR)
  - default ADDR_W/DATA_W/DEPTH constants
  - DISP_LATENCY=3
- One sub-module, fb_clear_sweeper:
  - Contains the address counter, the captured colour, and the last-address detect.
  - Driven by start/advance inputs.

Test Plan:
1. Reset, then disp_req at addr 5 with RAM model returning 24'hABCDEF -> mem_re=1, addr 5 at N+1; disp_valid=1, disp_data=24'hABCDEF at N+3.
2. wr_req addr 100, data 24'h00FF00, with no display traffic -> wr_ack at N; mem_we=1, addr 100, data 24'h00FF00 at N+1; exactly one write.
3. disp_req and wr_req together for 3 cycles, then disp_req drops -> no wr_ack during overlap; wr_ack on the first cycle without disp_req.
4. clr_req, clr_color=24'hFFFFFF, DEPTH=16, display idle -> 16 writes to addrs 0..15 on consecutive cycles; clr_done pulses once; clr_busy low afterwards; a wr_req held throughout is acked only after clr_done.
5. Clear with disp_req every other cycle, then rst asserted at counter=7 -> reads are never delayed; clear advances only in free slots; after rst, clr_busy=0, no clr_done, all mem_* outputs 0.
6. With FB_ARB_STALL_CNT_EN: wr_req blocked by disp_req for 4 cycles -> stall_cnt=4; then clr_req -> stall_cnt=0.
